// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with a direct-mapped instruction cache.
//
// Holds the architectural fetch PC and looks it up in a 2^IDX_W-line cache
// of 16-byte lines. A hit presents one instruction per cycle to the decoder;
// a miss requests one line fill from the memory controller and waits for it.
// The ROB may redirect the PC at any time with rollback.
//
// Optional feature: define IFETCH_PREDICT_EN to enable static prediction
// (JAL and backward conditional branches predicted taken). Without it the
// next PC is always pc+4 and inst_pre_j stays 0.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   rdy          global enable, every register holds when 0
//   stall        downstream full, no instruction may be issued
//   rollback     ROB redirect request
//   rollback_pc  redirect target
//   inst_done    registered, inst/inst_pc/inst_pre_j are valid this cycle
//   inst         fetched instruction word
//   inst_pc      address of inst
//   inst_pre_j   instruction was predicted taken
//   mc_en        line-fill request to the memory controller
//   mc_addr      line address of the request, [3:0] always 0
//   mc_done      one-cycle pulse, mc_data is valid
//   mc_data      line data, word k at [32k+31:32k]
module ifetch #(
  parameter int unsigned IDX_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         stall,
  input  logic         rollback,
  input  logic [31:0]  rollback_pc,
  output logic         inst_done,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic         inst_pre_j,
  output logic         mc_en,
  output logic [31:0]  mc_addr,
  input  logic         mc_done,
  input  logic [127:0] mc_data
);

  localparam int unsigned Lines = 1 << IDX_W;
  localparam int unsigned TagW  = 28 - IDX_W;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        inst_done_d;
  logic [31:0] inst_d;
  logic [31:0] inst_pc_d;
  logic        inst_pre_j_d;
  logic        mc_en_d;
  logic [31:0] mc_addr_d;

  // Cache storage. Only the valid bits are reset; tags and data are
  // meaningless until the matching valid bit is set by a fill.
  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [127:0]     data_q [Lines];

  // Lookup of the current fetch PC.
  logic [IDX_W-1:0] lk_idx;
  logic [TagW-1:0]  lk_tag;
  logic [1:0]       lk_off;
  logic [127:0]     lk_line;
  logic [31:0]      hit_word;
  logic             hit;

  assign lk_idx   = pc_q[IDX_W+3:4];
  assign lk_tag   = pc_q[31:IDX_W+4];
  assign lk_off   = pc_q[3:2];
  assign lk_line  = data_q[lk_idx];
  assign hit_word = lk_line[{lk_off, 5'b0} +: 32];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // The fill always targets the line named by the outstanding request, even
  // if the PC was redirected while waiting.
  logic [IDX_W-1:0] fill_idx;
  logic [TagW-1:0]  fill_tag;
  logic             fill_we;

  assign fill_idx = mc_addr[IDX_W+3:4];
  assign fill_tag = mc_addr[31:IDX_W+4];

  // Next PC after a hit.
  logic        pred_taken;
  logic [31:0] pred_npc;

`ifdef IFETCH_PREDICT_EN
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign j_imm = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
  assign b_imm = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    pred_npc   = pc_q + 32'd4;
    if (hit_word[6:0] == 7'b1101111) begin
      pred_taken = 1'b1;
      pred_npc   = pc_q + j_imm;
    end else if (hit_word[6:0] == 7'b1100011 && hit_word[31]) begin
      // Backward conditional branch: assume a loop and predict taken.
      pred_taken = 1'b1;
      pred_npc   = pc_q + b_imm;
    end
  end
`else
  assign pred_taken = 1'b0;
  assign pred_npc   = pc_q + 32'd4;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_done_d  = 1'b0;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_pre_j_d = inst_pre_j;
    mc_en_d      = mc_en;
    mc_addr_d    = mc_addr;
    fill_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rollback) begin
          pc_d = rollback_pc;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (hit) begin
          inst_done_d  = 1'b1;
          inst_d       = hit_word;
          inst_pc_d    = pc_q;
          inst_pre_j_d = pred_taken;
          pc_d         = pred_npc;
        end else begin
          mc_en_d   = 1'b1;
          mc_addr_d = {pc_q[31:4], 4'b0};
          state_d   = StWait;
        end
      end
      StWait: begin
        if (mc_done) begin
          fill_we = 1'b1;
          mc_en_d = 1'b0;
          state_d = StIdle;
        end
        // No abort path to memory: the fill still lands, only the PC moves.
        if (rollback) begin
          pc_d = rollback_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= 32'd0;
      inst_done  <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_pre_j <= 1'b0;
      mc_en      <= 1'b0;
      mc_addr    <= 32'd0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_done  <= inst_done_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_pre_j <= inst_pre_j_d;
      mc_en      <= mc_en_d;
      mc_addr    <= mc_addr_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc_data;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by a random
// phase, all checked cycle by cycle against a transaction-level model of the
// fetch stage (PC, a set of cached line tags, and a memory image function).
module tb_ifetch;

  localparam int unsigned IDX_W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         stall;
  logic         rollback;
  logic [31:0]  rollback_pc;
  logic         inst_done;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_pre_j;
  logic         mc_en;
  logic [31:0]  mc_addr;
  logic         mc_done;
  logic [127:0] mc_data;

  always #5 clk = ~clk;

  ifetch #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .stall      (stall),
    .rollback   (rollback),
    .rollback_pc(rollback_pc),
    .inst_done  (inst_done),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_pre_j (inst_pre_j),
    .mc_en      (mc_en),
    .mc_addr    (mc_addr),
    .mc_done    (mc_done),
    .mc_data    (mc_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_wait;
  bit          m_done;
  logic [31:0] m_inst;
  logic [31:0] m_inst_pc;
  bit          m_pre_j;
  bit          m_en;
  logic [31:0] m_addr;
  int unsigned m_tag [int unsigned];

  // Memory responder state.
  bit busy;
  int cnt;
  bit rand_lat;

  // Observed history.
  logic [31:0] issued_pc [$];
  bit          issued_pj [$];
  logic [31:0] reqs      [$];
  bit          prev_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h20) return 32'hFF9FF06F;  // jal x0, -8
    if (a == 32'h24) return 32'h00000863;  // beq x0, x0, +16
    h = (a ^ 32'h1234_5678) * 32'h9E37_79B1;
    return {h[31:7], 7'b0010011};
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'hF;
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  function automatic int unsigned line_idx(input logic [31:0] a);
    return (a >> 4) % (32'd1 << IDX_W);
  endfunction

  function automatic int unsigned line_tag(input logic [31:0] a);
    return a >> (IDX_W + 4);
  endfunction

  function automatic bit cached(input logic [31:0] a);
    return m_tag.exists(line_idx(a)) && (m_tag[line_idx(a)] == line_tag(a));
  endfunction

  task automatic predict(input logic [31:0] w, input logic [31:0] pc, output bit taken,
                         output logic [31:0] npc);
    int imm;
    taken = 1'b0;
    npc   = pc + 32'd4;
    imm   = 0;
`ifdef IFETCH_PREDICT_EN
    if ((w & 32'h7F) == 32'h6F) begin
      imm = int'((((w >> 21) & 32'h3FF) << 1) | (((w >> 20) & 32'h1) << 11) |
                 (((w >> 12) & 32'hFF) << 12));
      if (w[31]) imm = imm - (1 << 20);
      taken = 1'b1;
      npc   = pc + 32'(imm);
    end else if ((w & 32'h7F) == 32'h63 && w[31]) begin
      imm = int'((((w >> 8) & 32'hF) << 1) | (((w >> 25) & 32'h3F) << 5) |
                 (((w >> 7) & 32'h1) << 11));
      imm   = imm - (1 << 12);
      taken = 1'b1;
      npc   = pc + 32'(imm);
    end
`endif
  endtask

  task automatic model_step(input bit r_rst, input bit r_rdy, input bit r_stall, input bit r_rb,
                            input logic [31:0] r_rbpc, input bit r_mcd);
    bit          tk;
    logic [31:0] npc;
    if (!r_rst) begin
      m_wait = 0; m_pc = 0; m_done = 0; m_inst = 0; m_inst_pc = 0; m_pre_j = 0;
      m_en = 0; m_addr = 0;
      m_tag.delete();
    end else if (r_rdy) begin
      m_done = 0;
      if (m_wait) begin
        if (r_mcd) begin
          m_tag[line_idx(m_addr)] = line_tag(m_addr);
          m_wait = 0;
          m_en   = 0;
        end
        if (r_rb) m_pc = r_rbpc;
      end else if (r_rb) begin
        m_pc = r_rbpc;
      end else if (!r_stall) begin
        if (cached(m_pc)) begin
          m_done    = 1;
          m_inst    = mem_word(m_pc);
          m_inst_pc = m_pc;
          predict(m_inst, m_pc, tk, npc);
          m_pre_j   = tk;
          m_pc      = npc;
        end else begin
          m_en   = 1;
          m_addr = m_pc & ~32'hF;
          m_wait = 1;
        end
      end
    end
  endtask

  // One clock: inputs stay as set, outputs are sampled at the falling edge.
  task automatic cycle();
    bit          s_rst, s_rdy, s_stall, s_rb, s_mcd;
    logic [31:0] s_rbpc;
    s_rst = rst; s_rdy = rdy; s_stall = stall; s_rb = rollback; s_rbpc = rollback_pc;
    s_mcd = mc_done;
    @(posedge clk);
    @(negedge clk);
    model_step(s_rst, s_rdy, s_stall, s_rb, s_rbpc, s_mcd);
    chk("inst_done", 32'(inst_done), 32'(m_done));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_inst_pc);
    chk("inst_pre_j", 32'(inst_pre_j), 32'(m_pre_j));
    chk("mc_en", 32'(mc_en), 32'(m_en));
    chk("mc_addr", mc_addr, m_addr);
    if (inst_done) begin
      issued_pc.push_back(inst_pc);
      issued_pj.push_back(inst_pre_j);
    end
    if (mc_en && !prev_en) reqs.push_back(mc_addr);
    prev_en = mc_en;
    // Memory controller, gated by rdy like the rest of the pipeline.
    if (s_rdy) begin
      if (mc_done) begin
        mc_done = 1'b0;
      end else if (busy) begin
        if (cnt > 1) begin
          cnt--;
        end else begin
          mc_done = 1'b1;
          mc_data = line_data(mc_addr);
          busy    = 1'b0;
        end
      end else if (mc_en) begin
        busy = 1'b1;
        cnt  = rand_lat ? int'($urandom_range(1, 4)) : 3;
      end
    end
  endtask

  task automatic run_until_issued(input int n, input int budget);
    int k = 0;
    while (issued_pc.size() < n && k < budget) begin
      cycle();
      k++;
    end
    if (issued_pc.size() < n) chk("timeout_issue", 32'd0, 32'd1);
  endtask

  task automatic run_until_req(input int n, input int budget);
    int k = 0;
    while (reqs.size() < n && k < budget) begin
      cycle();
      k++;
    end
    if (reqs.size() < n) chk("timeout_req", 32'd0, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    rollback    = 1'b1;
    rollback_pc = target;
    cycle();
    rollback    = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    bit found;
    rst = 1'b0; rdy = 1'b1; stall = 1'b0; rollback = 1'b0; rollback_pc = 32'd0;
    mc_done = 1'b0; mc_data = '0;
    busy = 1'b0; cnt = 0; rand_lat = 1'b0; prev_en = 1'b0;

    // Reset and first line fill, with a 3-cycle stall at pc 0x8.
    cycle();
    cycle();
    rst = 1'b1;
    run_until_issued(2, 50);
    stall = 1'b1;
    n = issued_pc.size();
    repeat (3) cycle();
    chk("stall_no_issue", 32'(issued_pc.size()), 32'(n));
    stall = 1'b0;
    run_until_issued(4, 20);
    if (issued_pc.size() >= 4) begin
      chk("seq0", issued_pc[0], 32'h0);
      chk("seq1", issued_pc[1], 32'h4);
      chk("seq2_after_stall", issued_pc[2], 32'h8);
      chk("seq3", issued_pc[3], 32'hC);
    end
    run_until_req(2, 20);
    if (reqs.size() >= 2) begin
      chk("req_first", reqs[0], 32'h0);
      chk("req_next_line", reqs[1], 32'h10);
    end

    // Rollback while waiting on line 0x10.
    redirect(32'h40);
    run_until_req(3, 30);
    if (reqs.size() >= 3) chk("req_after_rb", reqs[2], 32'h40);
    run_until_issued(issued_pc.size() + 1, 30);
    chk("issue_rb_target", issued_pc[$], 32'h40);
    redirect(32'h10);
    n = reqs.size();
    run_until_issued(issued_pc.size() + 1, 30);
    chk("issue_0x10", issued_pc[$], 32'h10);
    chk("no_refill_0x10", 32'(reqs.size()), 32'(n));

    // Rollback in the same cycle as mc_done.
    redirect(32'h80);
    k = 0;
    while (!mc_done && k < 30) begin
      cycle();
      k++;
    end
    if (!mc_done) chk("timeout_mc_done", 32'd0, 32'd1);
    redirect(32'h84);
    run_until_issued(issued_pc.size() + 1, 30);
    chk("rb_with_done", issued_pc[$], 32'h84);

    // Static prediction around the planted JAL at 0x20.
    redirect(32'h18);
    found = 1'b0;
    k = 0;
    while (!found && k < 6) begin
      run_until_issued(issued_pc.size() + 1, 30);
      found = (issued_pc[$] == 32'h20);
      k++;
    end
    chk("reach_jal", 32'(found), 32'd1);
    chk("jal_pre_j", 32'(issued_pj[$]), 32'(`ifdef IFETCH_PREDICT_EN 1 `else 0 `endif));
    run_until_issued(issued_pc.size() + 1, 30);
    chk("jal_next", issued_pc[$], `ifdef IFETCH_PREDICT_EN 32'h18 `else 32'h24 `endif);
    redirect(32'h24);
    run_until_issued(issued_pc.size() + 1, 30);
    chk("beq_pc", issued_pc[$], 32'h24);
    chk("beq_pre_j", 32'(issued_pj[$]), 32'd0);
    run_until_issued(issued_pc.size() + 1, 30);
    chk("beq_next", issued_pc[$], 32'h28);

    // Index aliasing: 0x100 and 0x000 share a line.
    redirect(32'h100);
    n = reqs.size();
    run_until_req(n + 1, 30);
    if (reqs.size() > n) chk("alias_req_100", reqs[n], 32'h100);
    run_until_issued(issued_pc.size() + 1, 30);
    chk("alias_issue_100", issued_pc[$], 32'h100);
    redirect(32'h0);
    n = reqs.size();
    run_until_req(n + 1, 30);
    if (reqs.size() > n) chk("alias_req_000", reqs[n], 32'h0);

    // Reset in the middle of a fill; the late mc_done must be ignored.
    redirect(32'h200);
    run_until_req(reqs.size() + 1, 40);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("reset_mid_fill_mc_en", 32'(mc_en), 32'd0);
    repeat (10) cycle();

    // Random traffic.
    rand_lat = 1'b1;
    n = issued_pc.size();
    for (int i = 0; i < 3000; i++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      rollback = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) rollback_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
      else rollback_pc = $urandom_range(0, 1023) << 2;
      rst = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst = 1'b1; rdy = 1'b1; stall = 1'b0; rollback = 1'b0;
    repeat (5) cycle();
    chk("random_progress", 32'(issued_pc.size() > n + 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the out-of-order RISC-V core. Holds the architectural fetch PC and looks it up in a direct-mapped instruction cache. On a miss it fills one cache line through the memory controller. On a hit it presents one instruction per cycle, with PC and prediction bit, to the decoder. It sits between the memory controller and the decoder, and is redirected by the ROB on rollback.

## Interface
Parameters:
- `IDX_W`, default 4: cache index width; the cache has 2^IDX_W lines of 16 bytes (4 words).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low: state resets on a rising edge where `rst`==0.
- `rdy`  in  1  global enable; when 0, every register holds.
- `stall`  in  1  downstream (ROB/RS/LSB) full; fetch must not issue.
- `rollback`  in  1  ROB misprediction redirect.
- `rollback_pc`  in  32  redirect target.
- `inst_done`  out  1  registered; `inst` is valid this cycle.
- `inst`  out  32  fetched instruction word.
- `inst_pc`  out  32  address of `inst`.
- `inst_pre_j`  out  1  the instruction was predicted taken.
- `mc_en`  out  1  line-fill request to the memory controller.
- `mc_addr`  out  32  line address, with `[3:0]`==0.
- `mc_done`  in  1  one-cycle pulse: `mc_data` is valid.
- `mc_data`  in  128  line data; word k is at `[32k+31:32k]`.

## Operation
- Address split:
  - offset = `pc[3:2]`
  - index = `pc[IDX_W+3:4]`
  - tag = `pc[31:IDX_W+4]`
- Per-line storage: valid bit, tag, and 4 words.
- State machine IDLE, in an active cycle (`rst`=1, `rdy`=1):
  - `rollback`=1: `pc`<=`rollback_pc`; `inst_done`<=0. This has priority over everything else.
  - Otherwise, `stall`=1: `inst_done`<=0; `pc` holds.
  - Otherwise, hit: `inst_done`<=1; `inst`<=word at offset; `inst_pc`<=`pc`; `inst_pre_j`<=prediction; `pc`<=next PC.
  - Otherwise, miss: `inst_done`<=0; `mc_en`<=1; `mc_addr`<={`pc[31:4]`,4'b0}; state<=WAIT.
- State machine WAIT:
  - `inst_done` is 0 throughout.
  - `mc_en` and `mc_addr` are held stable.
  - On `mc_done`:
    - write `mc_data`, the tag, and valid=1 into the line at `mc_addr`'s index;
    - `mc_en`<=0;
    - state<=IDLE.
  - `rollback` in WAIT:
    - `pc`<=`rollback_pc` immediately;
    - the outstanding fill still completes and is written;
    - there is no abort signal to the memory controller.
- Next PC is `pc+4` (mod 2^32) unless a prediction is taken (see Configuration).
- Reset values:
  - `inst_done`=0, `inst`=0, `inst_pc`=0, `inst_pre_j`=0;
  - `mc_en`=0, `mc_addr`=0;
  - `pc`=0; state=IDLE; all valid bits=0.
  - Cache data and tags are don't-care.
- Reset mid-fill returns to IDLE at once. A `mc_done` arriving later, while IDLE, is ignored.

## Timing
- Hit latency: `pc` is sampled at edge N; `inst_done`/`inst` are visible after edge N (one cycle). Hits sustain throughput of 1 instruction/cycle.
- `inst_done` is a per-instruction pulse. Each instruction is presented for exactly one active cycle; the decoder consumes it combinationally.
- Miss: `mc_en` rises at the edge after the miss lookup. If `mc_done` arrives at edge M, the line is valid after M and the hit is issued at edge M+1. The penalty is memory latency + 2 cycles.
- `rollback` and `mc_done` in the same cycle: the line is filled, state goes to IDLE, and `pc`=`rollback_pc`. The first fetch from the new PC is at the next edge.
- `rollback` and a hit in the same cycle: no instruction is issued.
- `rdy`=0 freezes all registers, including `inst_done`. Downstream is equally gated by `rdy`.

## Configuration
- `IFETCH_PREDICT_EN` defined: static prediction on the hit word. A taken prediction sets next PC to the target and `inst_pre_j`=1.
  - JAL (opcode 1101111): taken; target = `pc` + J-immediate.
  - Branch (opcode 1100011) with `inst[31]`=1 (backward): taken; target = `pc` + B-immediate.
  - All others: `pc+4`, `inst_pre_j`=0.
- `IFETCH_PREDICT_EN` undefined: next PC is always `pc+4` and `inst_pre_j` is tied to 0. The ROB resolves all jumps and branches via `rollback`.

## Test plan
- Reset, then `rst`=1 with memory latency 3 → `mc_en`=1, `mc_addr`=0x0. After `mc_done`, consecutive `inst_done` pulses follow with `inst_pc`=0x0, 0x4, 0x8, 0xC, then `mc_en` rises with `mc_addr`=0x10.
- `stall` held for 3 cycles during hit streaming at `pc`=0x8 → no `inst_done` for those 3 cycles; the next issue after release has `inst_pc`=0x8, with no skip or duplicate.
- `rollback`=1, `rollback_pc`=0x40 while in WAIT for line 0x10 → the fill completes, line 0x10 is valid, and the next request is `mc_addr`=0x40. Later fetches of 0x10 hit with no `mc_en`.
- `rollback` and `mc_done` in the same cycle → the fill is written and the first issued `inst_pc` equals `rollback_pc`.
- With `IFETCH_PREDICT_EN`: JAL x0,-8 at 0x20 → `inst_pre_j`=1 and the next `inst_pc`=0x18. BEQ +16 at 0x24 → `inst_pre_j`=0 and the next `inst_pc`=0x28. Without the macro, the JAL gives next `inst_pc`=0x24 and `inst_pre_j`=0.
- Index aliasing with `IDX_W`=4: fetch 0x000, then jump to 0x100 (same index, different tag) → a miss refill; returning to 0x000 misses again.
